// File: rtl/mbd_side_buffer_ctrl.sv
// Side-buffer controller for the MinBD router.
// Holds flits pulled out by the buffer-eject stage in a small FIFO and
// re-injects the head flit into the first free input slot. The slot scan
// starts at a rotating priority pointer. Ejection is throttled when the FIFO
// is full, and a starvation flag is raised when the head flit stays blocked.
module mbd_side_buffer_ctrl #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          eject_valid,
  input  logic [10:0]   eject_flit,
  input  logic [3:0]    slot_busy,
  output logic          eject_en,
  output logic          inj_valid,
  output logic [1:0]    inj_port,
  output logic [10:0]   inj_flit,
  output logic [CW-1:0] buf_count,
  output logic          buf_full,
  output logic          starve,
  output logic          ovf_err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {EMPTY, HOLD, STARVED} state_e;

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]    blk_cnt_q, blk_cnt_d;
  state_e        state_q, state_d;
  logic          ovf_q, ovf_d;
  logic          inj_valid_q;
  logic [1:0]    inj_port_q;
  logic [10:0]   inj_flit_q;

  logic          full;
  logic          found;
  logic [1:0]    sel;
  logic          pop;
  logic          push;

  assign full = (count_q == DEPTH_C);

  // Rotating-priority scan for the first free input slot, starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!found && !slot_busy[rr_ptr_q + 2'(i)]) begin
        found = 1'b1;
        sel   = rr_ptr_q + 2'(i);
      end
    end
  end

  // A pop frees the head entry on this edge, so a push is still accepted when
  // the FIFO is full as long as it coincides with a pop.
  assign pop  = (count_q != '0) && found;
  assign push = eject_valid && (!full || pop);

  // Next-state logic: pointers, occupancy, overflow flag and the starvation FSM.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rr_ptr_d  = rr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    blk_cnt_d = blk_cnt_q;
    state_d   = state_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rr_ptr_d = sel + 2'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (eject_valid && full && !pop) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      EMPTY: begin
        blk_cnt_d = '0;
        if (push) begin
          state_d = HOLD;
        end
      end
      HOLD, STARVED: begin
        if (pop) begin
          blk_cnt_d = '0;
          state_d   = (count_d == '0) ? EMPTY : HOLD;
        end else begin
          if (blk_cnt_q < LIMIT_C) begin
            blk_cnt_d = blk_cnt_q + 8'd1;
          end
          state_d = (blk_cnt_d >= LIMIT_C) ? STARVED : HOLD;
        end
      end
      default: begin
        blk_cnt_d = '0;
        state_d   = EMPTY;
      end
    endcase
  end

  // Control and output registers; reset discards all buffered flits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      blk_cnt_q   <= '0;
      state_q     <= EMPTY;
      inj_valid_q <= 1'b0;
      inj_port_q  <= '0;
      inj_flit_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      blk_cnt_q   <= blk_cnt_d;
      state_q     <= state_d;
      inj_valid_q <= pop;
      if (pop) begin
        inj_port_q <= sel;
        inj_flit_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Flit storage; entries are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= eject_flit;
    end
  end

  assign eject_en  = !full;
  assign inj_valid = inj_valid_q;
  assign inj_port  = inj_port_q;
  assign inj_flit  = inj_flit_q;
  assign buf_count = count_q;
  assign buf_full  = full;
  assign starve    = (state_q == STARVED);
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mbd_side_buffer_ctrl.sv
// Self-checking bench for mbd_side_buffer_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_mbd_side_buffer_ctrl;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        eject_valid;
  logic [10:0] eject_flit;
  logic [3:0]  slot_busy;
  logic        eject_en;
  logic        inj_valid;
  logic [1:0]  inj_port;
  logic [10:0] inj_flit;
  logic [2:0]  buf_count;
  logic        buf_full;
  logic        starve;
  logic        ovf_err;

  int ncmp = 0;
  int nerr = 0;

  // Reference model state
  logic [10:0] mq[$];
  int          rr;
  int          blk;
  bit          movf;
  bit          exp_v;
  int          exp_port;
  logic [10:0] exp_flit;

  mbd_side_buffer_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .eject_valid (eject_valid),
    .eject_flit  (eject_flit),
    .slot_busy   (slot_busy),
    .eject_en    (eject_en),
    .inj_valid   (inj_valid),
    .inj_port    (inj_port),
    .inj_flit    (inj_flit),
    .buf_count   (buf_count),
    .buf_full    (buf_full),
    .starve      (starve),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rr    = 0;
    blk   = 0;
    movf  = 1'b0;
    exp_v = 1'b0;
  endtask

  // One clock edge of the FIFO/injection rules, from the state before the edge.
  task automatic model_step(input logic ev, input logic [10:0] f, input logic [3:0] b);
    bit pop = 1'b0;
    int sel = 0;
    if (mq.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        int s = (rr + k) % 4;
        if (!pop && !b[s]) begin
          pop = 1'b1;
          sel = s;
        end
      end
    end
    exp_v = pop;
    if (pop) begin
      exp_port = sel;
      exp_flit = mq.pop_front();
      rr       = (sel + 1) % 4;
      blk      = 0;
    end else if (mq.size() > 0) begin
      if (blk < LIMIT) blk++;
    end else begin
      blk = 0;
    end
    if (ev) begin
      if (mq.size() < DEPTH) mq.push_back(f);
      else movf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("inj_valid", inj_valid, exp_v);
    if (exp_v) begin
      chk("inj_port", inj_port, exp_port);
      chk("inj_flit", inj_flit, exp_flit);
    end
    chk("buf_count", buf_count, mq.size());
    chk("buf_full", buf_full, mq.size() == DEPTH);
    chk("eject_en", eject_en, mq.size() != DEPTH);
    chk("starve", starve, blk >= LIMIT);
    chk("ovf_err", ovf_err, movf);
  endtask

  task automatic cycle(input logic ev, input logic [10:0] f, input logic [3:0] b);
    eject_valid = ev;
    eject_flit  = f;
    slot_busy   = b;
    model_step(ev, f, b);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    eject_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_eject_en", eject_en, 1);
    chk("rst_inj_valid", inj_valid, 0);
    chk("rst_inj_port", inj_port, 0);
    chk("rst_inj_flit", inj_flit, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_starve", starve, 0);
    chk("rst_ovf_err", ovf_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int phase;
    rst         = 1'b0;
    eject_valid = 1'b0;
    eject_flit  = '0;
    slot_busy   = 4'hF;
    model_reset();
    #2;
    apply_reset();

    // Idle after reset with every slot busy
    for (int i = 0; i < 5; i++) cycle(1'b0, 11'h0, 4'hF);
    chk("idle_eject_en", eject_en, 1);
    chk("idle_inj_valid", inj_valid, 0);

    // Single flit, all slots free: injected one edge after the push
    cycle(1'b1, 11'h1A5, 4'h0);
    chk("t2_count_after_push", buf_count, 1);
    chk("t2_no_bypass", inj_valid, 0);
    cycle(1'b0, 11'h0, 4'h0);
    chk("t2_valid", inj_valid, 1);
    chk("t2_port", inj_port, 0);
    chk("t2_flit", inj_flit, 11'h1A5);
    chk("t2_count", buf_count, 0);
    cycle(1'b0, 11'h0, 4'h0);
    chk("t2_pulse", inj_valid, 0);

    // Fill to full, overflow push, then drain in order on rotating ports
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 11'(11'h101 + i), 4'hF);
    chk("t3_full", buf_full, 1);
    chk("t3_eject_en", eject_en, 0);
    cycle(1'b1, 11'h105, 4'hF);
    chk("t3_ovf", ovf_err, 1);
    chk("t3_count", buf_count, 4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 11'h0, 4'h0);
      chk("t3_drain_port", inj_port, i);
      chk("t3_drain_flit", inj_flit, 11'h101 + i);
    end
    chk("t3_ovf_sticky", ovf_err, 1);

    // Starvation after STARVE_LIMIT blocked edges, cleared by injection
    apply_reset();
    cycle(1'b1, 11'h2AA, 4'hF);
    for (int i = 1; i <= LIMIT; i++) begin
      cycle(1'b0, 11'h0, 4'hF);
      if (i == LIMIT - 1) chk("t4_not_yet_starved", starve, 0);
    end
    chk("t4_starved", starve, 1);
    cycle(1'b0, 11'h0, 4'b1011);
    chk("t4_inj_port", inj_port, 2);
    chk("t4_starve_clear", starve, 0);

    // Full FIFO with push and pop on the same edge
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 11'(11'h301 + i), 4'hF);
    cycle(1'b1, 11'h305, 4'h0);
    chk("t5_count", buf_count, 4);
    chk("t5_ovf", ovf_err, 0);
    chk("t5_flit", inj_flit, 11'h301);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 11'h0, 4'h0);
      chk("t5_order", inj_flit, 11'h302 + i);
    end

    // Mid-operation reset discards buffered flits
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 11'(11'h3C0 + i), 4'hF);
    chk("t6_count", buf_count, 3);
    #2;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 11'h0, 4'h0);
      chk("t6_no_inject", inj_valid, 0);
    end

    // Randomized traffic with phases of free, blocked and mixed slots
    phase = 0;
    for (int n = 0; n < 800; n++) begin
      logic       ev;
      logic [3:0] b;
      if (n % 20 == 0) phase = $urandom_range(0, 2);
      if ($urandom_range(0, 299) == 0) apply_reset();
      ev = ($urandom_range(0, 99) < 55);
      case (phase)
        1:       b = 4'hF;
        2:       b = 4'h0;
        default: b = 4'($urandom);
      endcase
      cycle(ev, 11'($urandom), b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mbd_side_buffer_ctrl.md
Name: mbd_side_buffer_ctrl

Overview:
Side-buffer controller for the MinBD router. It accepts flits that the buffer-eject stage pulls out of the N/S/E/W input pipeline and holds them in a small FIFO. It re-injects the head flit into the first free input slot, chosen by rotating priority. It throttles further ejection when the FIFO is full and raises a starvation flag when the head flit cannot find a free slot for too long.

Parameters:
DEPTH, 4, number of 11-bit flit entries in the side buffer (power of 2, >= 2)
STARVE_LIMIT, 8, consecutive blocked cycles before starve asserts (1..255)
CW, 3, width of buf_count (log2(DEPTH)+1)

Ports:
clk  input  1  router clock, rising edge
rst  input  1  asynchronous active-high reset
eject_valid  input  1  eject stage presents a flit on eject_flit this cycle
eject_flit  input  11  ejected flit, format {ctl[10:9], dir[8:6], addr[5:0]}
slot_busy  input  4  input-slot occupancy; bit0 N, bit1 S, bit2 E, bit3 W; 1 = occupied
eject_en  output  1  eject stage may eject this cycle
inj_valid  output  1  inj_flit is driven into slot inj_port this cycle
inj_port  output  2  target slot: 0 N, 1 S, 2 E, 3 W
inj_flit  output  11  re-injected flit, unmodified from storage
buf_count  output  CW  current FIFO occupancy
buf_full  output  1  buf_count == DEPTH
starve  output  1  head flit blocked for >= STARVE_LIMIT cycles
ovf_err  output  1  sticky: push attempted while full

Behaviour:
- Reset (async, rst=1) clears the following immediately and holds them while rst is high: rd/wr pointers = 0, buf_count = 0, rr_ptr = 0, starve counter = 0, state = EMPTY. Outputs: inj_valid = 0, inj_port = 0, inj_flit = 0, buf_full = 0, starve = 0, ovf_err = 0. eject_en = 1.
- A reset asserted mid-operation discards all buffered flits. Nothing is re-injected after release until a new push.
- eject_en = (buf_count != DEPTH). It is combinational from registered count only, with no dependence on the same-cycle pop.
- Push: on a clk edge with eject_valid=1 and buf_count<DEPTH, eject_flit is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Push while full: the flit is ignored and ovf_err is set (sticky until reset).
- Pop/inject decision is evaluated each cycle when buf_count>0, using the registered head and the current slot_busy.
  - Scan slots rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4). Take the first with slot_busy=0.
  - If one is found, on the next edge: inj_valid=1, inj_port=that slot, inj_flit=head; rd_ptr increments; rr_ptr = slot+1 mod 4.
  - Otherwise inj_valid=0 on the next edge.
- Injection outputs are registered, so inj_valid is a one-cycle pulse per flit.
  - A flit pushed at edge t is first eligible at edge t+1, so its earliest inj_valid is after edge t+1. There is no same-cycle bypass.
- Simultaneous push and pop: buf_count unchanged; both pointers advance. This holds at full (the pop frees the entry written that edge) and at count=1.
- buf_count width is CW; it never exceeds DEPTH and never underflows.
- FSM (state held in a register):
  - EMPTY: buf_count=0. Go to HOLD on a push.
  - HOLD: nonempty and counter < STARVE_LIMIT.
    - Each edge with no free slot increments the counter.
    - Any injection clears the counter and moves to EMPTY if the count becomes 0, otherwise stays in HOLD.
    - When the counter reaches STARVE_LIMIT, go to STARVED.
  - STARVED: starve=1 (registered). The counter saturates. On an injection, clear the counter and starve, then go to EMPTY or HOLD.
- starve is advisory: the router uses it to force one input slot free. This block does not change priority while starved.

Test Plan:
- Reset then idle with slot_busy=4'b1111 -> eject_en=1, buf_count=0, inj_valid stays 0, starve=0.
- Push 11'h1A5 with slot_busy=4'b0000 after reset -> one cycle later inj_valid=1, inj_port=0, inj_flit=11'h1A5; buf_count returns to 0.
- Push 4 flits (0x101, 0x102, 0x103, 0x104) with slot_busy=4'b1111 -> buf_full=1, eject_en=0. A 5th push sets ovf_err=1 and buf_count stays 4. Then set slot_busy=4'b0000 -> the flits emerge in order on ports 0, 1, 2, 3 (rotating priority).
- Hold one flit with slot_busy=4'b1111 -> starve=1 after 8 blocked edges. Then release slot_busy=4'b1011 -> inj_port=2, and starve=0 on the same edge.
- Full FIFO, push and inject on the same edge -> buf_count stays 4, FIFO order preserved, ovf_err stays 0.
- Assert rst with buf_count=3 -> all outputs clear immediately. After release with slot_busy=0, no inj_valid.
